// File: rtl/cv32e40p_irq_ctrl.sv
// Interrupt pending/enable controller feeding the core's irq_i lines, with a small register port.
// Define CV32E40P_IRQ_CTRL_EDGE_EN to latch rising source edges; otherwise sources are level-sensitive.
module cv32e40p_irq_ctrl #(
  parameter logic [31:0] IRQ_EN_RESET = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] irq_src_i,
  output logic [31:0] irq_o,
  input  logic        irq_ack_i,
  input  logic [4:0]  irq_id_i,
  input  logic        cfg_req_i,
  output logic        cfg_gnt_o,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic        cfg_rvalid_o,
  output logic [31:0] cfg_rdata_o
);

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_CLEAR   = 2'd1;
  localparam logic [1:0] REG_ENABLE  = 2'd2;
  localparam logic [1:0] REG_ACTIVE  = 2'd3;

  logic [31:0] pending_q, pending_d;
  logic [31:0] enable_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [31:0] sw_set, clr_mask, rd_val;
  logic [1:0]  sel;
  logic        wr;
  logic        unused_addr_lsb;

  assign sel             = cfg_addr_i[3:2];
  assign unused_addr_lsb = ^cfg_addr_i[1:0];
  assign wr              = cfg_req_i & cfg_we_i;
  assign cfg_gnt_o       = cfg_req_i;
  assign irq_o           = pending_q & enable_q;
  assign cfg_rvalid_o    = rvalid_q;
  assign cfg_rdata_o     = rdata_q;

  always_comb begin
    sw_set   = (wr && sel == REG_PENDING) ? cfg_wdata_i : 32'h0;
    clr_mask = (wr && sel == REG_CLEAR) ? cfg_wdata_i : 32'h0;
    if (irq_ack_i) clr_mask = clr_mask | (32'h1 << irq_id_i);
  end

`ifdef CV32E40P_IRQ_CTRL_EDGE_EN
  logic [31:0] src_q;

  // Sets are OR-ed in after clears so a same-cycle set always wins.
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | sw_set | (irq_src_i & ~src_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) src_q <= 32'h0;
    else       src_q <= irq_src_i;
  end
`else
  logic [31:0] sw_pending_q, sw_pending_d;

  // Level sources bypass the software state, so neither CLEAR nor ack can hide them.
  always_comb begin
    sw_pending_d = (sw_pending_q & ~clr_mask) | sw_set;
    pending_d    = irq_src_i | sw_pending_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sw_pending_q <= 32'h0;
    else       sw_pending_q <= sw_pending_d;
  end
`endif

  always_comb begin
    rd_val = 32'h0;
    case (sel)
      REG_PENDING: rd_val = pending_q;
      REG_CLEAR:   rd_val = 32'h0;
      REG_ENABLE:  rd_val = enable_q;
      REG_ACTIVE:  rd_val = pending_q & enable_q;
      default:     rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 32'h0;
      enable_q  <= IRQ_EN_RESET;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      pending_q <= pending_d;
      if (wr && sel == REG_ENABLE) enable_q <= cfg_wdata_i;
      rvalid_q  <= cfg_req_i;
      rdata_q   <= (cfg_req_i && !cfg_we_i) ? rd_val : 32'h0;
    end
  end

endmodule
